input_controller: RTL and testbench

Front-end conditioner between the board's switches/button and the processor's IN instruction path inside `geral`. It synchronizes `switch_imediato` and `switch_continue`, debounces the button, and emits a single-cycle press pulse for manual clock stepping. It also runs a request/valid handshake that delivers one extended switch value to the control unit per IN instruction.

---
 rtl/input_controller.sv | 145 ++++++++++++++
 tb/tb_input_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_controller.sv
// Switch/button front end for the IN instruction: synchronizers, debouncer, press pulse and request/valid handshake.
// Optional macro INPUT_DEBOUNCE_EN enables the debounce counter; without it the button level is taken as-is.
module input_controller #(
   parameter int DATA_WIDTH      = 4,
   parameter int EXT_WIDTH       = 32,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SIGN_EXTEND     = 0
) (
   input  logic                  input_clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] switch_imediato,
   input  logic                  switch_continue,
   input  logic                  in_req,
   output logic [EXT_WIDTH-1:0]  in_data,
   output logic                  in_valid,
   output logic                  waiting,
   output logic                  press_pulse
);

   if (EXT_WIDTH < DATA_WIDTH || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("input_controller: EXT_WIDTH must be >= DATA_WIDTH and DEBOUNCE_CYCLES >= 1");
   end

   // Handshake: in_req is a level held by the control unit until it has seen in_valid;
   // in_valid is a one-cycle pulse and in_data is valid in that cycle (and held afterwards).

   logic [1:0]            cont_sync;
   logic                  cont_s;
   logic [DATA_WIDTH-1:0] sw_meta;
   logic [DATA_WIDTH-1:0] sw_s;
   logic                  deb;

   assign cont_s = cont_sync[1];

   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         cont_sync <= '0;
         sw_meta   <= '0;
         sw_s      <= '0;
      end else begin
         cont_sync <= {cont_sync[0], switch_continue};
         sw_meta   <= switch_imediato;
         sw_s      <= sw_meta;
      end
   end

`ifdef INPUT_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] deb_cnt;
   logic             deb_q;

   // Counter only runs while the synchronized level disagrees with the accepted one.
   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         deb         <= 1'b0;
         deb_q       <= 1'b0;
         deb_cnt     <= '0;
         press_pulse <= 1'b0;
      end else begin
         deb_q       <= deb;
         press_pulse <= deb & ~deb_q;
         if (cont_s == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == CNT_LAST) begin
            deb     <= cont_s;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end
`else
   // Fast-simulation build: deb simply trails cont_s by one cycle, so the edge is seen one stage earlier.
   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         deb         <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         deb         <= cont_s;
         press_pulse <= cont_s & ~deb;
      end
   end
`endif

   logic [EXT_WIDTH-1:0] sw_ext;

   always_comb begin
      if (SIGN_EXTEND != 0) sw_ext = EXT_WIDTH'($signed(sw_s));
      else                  sw_ext = EXT_WIDTH'(sw_s);
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_PRESS = 2'd1,
      DELIVER    = 2'd2,
      WAIT_DROP  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   capture;

   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         in_data <= '0;
      end else begin
         state <= state_nxt;
         if (capture) in_data <= sw_ext;
      end
   end

   // A dropped request wins over a simultaneous press; WAIT_DROP guarantees one press per request.
   always_comb begin
      state_nxt = state;
      waiting   = 1'b0;
      in_valid  = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (in_req) state_nxt = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            waiting = 1'b1;
            if (!in_req) begin
               state_nxt = IDLE;
            end else if (press_pulse) begin
               capture   = 1'b1;
               state_nxt = DELIVER;
            end
         end
         DELIVER: begin
            in_valid  = 1'b1;
            state_nxt = WAIT_DROP;
         end
         WAIT_DROP: begin
            if (!in_req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_input_controller.sv
// Bench for input_controller: a window-based button model plus request model checked every cycle,
// with directed scenarios and literal expectations for latency and captured data.
module tb_input_controller;

   localparam int D = 4;
`ifdef INPUT_DEBOUNCE_EN
   localparam int WIN     = D;
   localparam int LAG     = 1;
   localparam int EXP_LAT = 7;
`else
   localparam int WIN     = 1;
   localparam int LAG     = 0;
   localparam int EXP_LAT = 3;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  sw;
   logic        cont;
   logic        req;
   logic [31:0] data_z, data_s;
   logic        valid_z, valid_s, wait_z, wait_s, pulse_z, pulse_s;

   int checks = 0;
   int errors = 0;

   input_controller #(.DATA_WIDTH(4), .EXT_WIDTH(32), .DEBOUNCE_CYCLES(D), .SIGN_EXTEND(0)) dut_z (
      .input_clock(clk), .reset(rst), .switch_imediato(sw), .switch_continue(cont), .in_req(req),
      .in_data(data_z), .in_valid(valid_z), .waiting(wait_z), .press_pulse(pulse_z));

   input_controller #(.DATA_WIDTH(4), .EXT_WIDTH(32), .DEBOUNCE_CYCLES(D), .SIGN_EXTEND(1)) dut_s (
      .input_clock(clk), .reset(rst), .switch_imediato(sw), .switch_continue(cont), .in_req(req),
      .in_data(data_s), .in_valid(valid_s), .waiting(wait_s), .press_pulse(pulse_s));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // model: button accepted when the last WIN synchronized samples all differ from the held level
   bit          raw_h[$];
   logic [3:0]  sw_h[$];
   bit          lvl, rose, rose_prev, exp_pulse, pulse_in, all_diff;
   int          mode;        // 0 no request, 1 waiting for press, 2 delivering, 3 request consumed
   logic [3:0]  cap;
   logic [31:0] exp_z, exp_s;

   task automatic model_reset();
      raw_h = {};
      sw_h  = {};
      for (int i = 0; i < 8; i++) begin
         raw_h.push_back(1'b0);
         sw_h.push_back(4'h0);
      end
      lvl = 0; rose_prev = 0; exp_pulse = 0; mode = 0; cap = 4'h0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (rst) begin
            model_reset();
         end else begin
            pulse_in = exp_pulse;
            raw_h.push_front(cont); void'(raw_h.pop_back());
            sw_h.push_front(sw);    void'(sw_h.pop_back());
            all_diff = 1;
            for (int i = 2; i < WIN + 2; i++) if (raw_h[i] == lvl) all_diff = 0;
            rose = 0;
            if (all_diff) begin
               rose = !lvl;
               lvl  = !lvl;
            end
            exp_pulse = (LAG == 1) ? rose_prev : rose;
            rose_prev = rose;
            case (mode)
               0: if (req) mode = 1;
               1: if (!req) mode = 0;
                  else if (pulse_in) begin cap = sw_h[2]; mode = 2; end
               2: mode = 3;
               default: if (!req) mode = 0;
            endcase
         end
         exp_z = {28'h0, cap};
         exp_s = {{28{cap[3]}}, cap};
         #1;
         chk("press_pulse_z", 32'(pulse_z), 32'(exp_pulse));
         chk("press_pulse_s", 32'(pulse_s), 32'(exp_pulse));
         chk("in_valid_z",    32'(valid_z), 32'(mode == 2));
         chk("in_valid_s",    32'(valid_s), 32'(mode == 2));
         chk("waiting_z",     32'(wait_z),  32'(mode == 1));
         chk("waiting_s",     32'(wait_s),  32'(mode == 1));
         chk("in_data_z",     data_z, exp_z);
         chk("in_data_s",     data_s, exp_s);
      end
   end

   // driver tasks
   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hold, output int lat);
      bit found;
      @(negedge clk);
      cont  = 1'b1;
      lat   = -1;
      found = 0;
      for (int k = 1; k <= 60 && !found; k++) begin
         @(posedge clk);
         #1;
         if (pulse_z) begin
            lat   = k;
            found = 1;
         end
      end
      idle_cycles(hold);
      cont = 1'b0;
      idle_cycles(D + 8);
   endtask

   int lat;
   int npulse;
   int first;

   initial begin
      rst = 1'b1; sw = 4'h0; cont = 1'b0; req = 1'b0;

      // reset held 100 ns with random inputs
      repeat (10) begin
         @(negedge clk);
         sw   = 4'($urandom_range(0, 15));
         cont = 1'($urandom_range(0, 1));
         req  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      rst = 1'b0; sw = 4'h0; cont = 1'b0; req = 1'b0;
      idle_cycles(10);

      // basic IN
      sw = 4'b0101; req = 1'b1;
      idle_cycles(3);
      chk("basic_waiting_lit", 32'(wait_z), 32'd1);
      press(10, lat);
      chk("basic_latency_lit", 32'(lat), 32'(EXP_LAT));
      chk("basic_data_lit", data_z, 32'h0000_0005);
      chk("basic_waiting_after_lit", 32'(wait_z), 32'd0);
      req = 1'b0;
      idle_cycles(4);

      // sign extension
      sw = 4'b1010; req = 1'b1;
      idle_cycles(3);
      press(2, lat);
      chk("sign_data_s_lit", data_s, 32'hFFFF_FFFA);
      chk("sign_data_z_lit", data_z, 32'h0000_000A);
      req = 1'b0;
      idle_cycles(4);

`ifdef INPUT_DEBOUNCE_EN
      // bounce rejection
      req = 1'b1;
      idle_cycles(3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cont = (i % 2 == 0);
      end
      @(negedge clk);
      cont = 1'b0;
      idle_cycles(20);
      chk("bounce_waiting_lit", 32'(wait_z), 32'd1);
      chk("bounce_data_lit", data_s, 32'hFFFF_FFFA);
      req = 1'b0;
      idle_cycles(4);
`endif

      // press with no request
      sw = 4'b0011;
      press(2, lat);
      chk("noreq_latency_lit", 32'(lat), 32'(EXP_LAT));
      chk("noreq_data_lit", data_s, 32'hFFFF_FFFA);

      // request held after delivery: second press consumed nothing
      req = 1'b1;
      idle_cycles(3);
      press(2, lat);
      chk("held_first_lit", data_z, 32'h0000_0003);
      sw = 4'b0110;
      press(2, lat);
      chk("held_second_lit", data_z, 32'h0000_0003);
      req = 1'b0;
      idle_cycles(2);
      req = 1'b1;
      idle_cycles(3);
      press(2, lat);
      chk("rearm_data_lit", data_z, 32'h0000_0006);
      req = 1'b0;
      idle_cycles(4);

      // request dropped while waiting
      req = 1'b1;
      idle_cycles(3);
      chk("drop_waiting_lit", 32'(wait_z), 32'd1);
      req = 1'b0;
      idle_cycles(2);
      chk("drop_idle_lit", 32'(wait_z), 32'd0);
      chk("drop_data_lit", data_z, 32'h0000_0006);

      // reset mid-wait with the button held through release
      sw = 4'b1001; req = 1'b1;
      idle_cycles(3);
      @(negedge clk);
      cont = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_async_data_lit", data_s, 32'h0);
      chk("rst_async_wait_lit", 32'(wait_s), 32'd0);
      chk("rst_async_pulse_lit", 32'(pulse_s), 32'd0);
      idle_cycles(3);
      @(negedge clk);
      rst    = 1'b0;
      npulse = 0;
      first  = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (pulse_z) begin
            npulse++;
            if (first < 0) first = k;
         end
      end
      chk("rst_hold_pulses_lit", 32'(npulse), 32'd1);
      chk("rst_hold_latency_lit", 32'(first), 32'(EXP_LAT));
      chk("rst_hold_data_lit", data_s, 32'hFFFF_FFF9);
      @(negedge clk);
      cont = 1'b0;
      req  = 1'b0;
      idle_cycles(D + 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
